// File: rtl/vga_rect_filler_if.sv
// Command and video-memory write bundle for vga_rect_filler.
// Master drives a rectangle command and observes busy/done and the pixel write stream.
interface vga_rect_filler_if #(
   parameter int X_WIDTH      = 9,
   parameter int Y_WIDTH      = 8,
   parameter int COLOUR_WIDTH = 3
);
   logic                    start;
   logic [X_WIDTH-1:0]      rect_x;
   logic [Y_WIDTH-1:0]      rect_y;
   logic [X_WIDTH-1:0]      rect_w;
   logic [Y_WIDTH-1:0]      rect_h;
   logic [COLOUR_WIDTH-1:0] rect_colour;
   logic                    busy;
   logic                    done;
   logic [X_WIDTH-1:0]      x;
   logic [Y_WIDTH-1:0]      y;
   logic [COLOUR_WIDTH-1:0] colour;
   logic                    plot;

   modport master (
      output start, rect_x, rect_y, rect_w, rect_h, rect_colour,
      input  busy, done, x, y, colour, plot
   );

   modport slave (
      input  start, rect_x, rect_y, rect_w, rect_h, rect_colour,
      output busy, done, x, y, colour, plot
   );
endinterface

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one raster-order pixel write per clock, first plot the cycle after start.
// Optional feature macro VGA_RECT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module vga_rect_filler #(
   parameter int X_WIDTH      = 9,
   parameter int Y_WIDTH      = 8,
   parameter int COLOUR_WIDTH = 3,
   parameter int SCREEN_W     = 320,
   parameter int SCREEN_H     = 240
) (
   input logic               clock,
   input logic               reset,
   vga_rect_filler_if.slave  bus
);
`ifdef VGA_RECT_CLIP_EN
   localparam int SUM_XW = X_WIDTH + 1;
   localparam int SUM_YW = Y_WIDTH + 1;
`else
   localparam int SUM_XW = X_WIDTH;
   localparam int SUM_YW = Y_WIDTH;
`endif

   localparam logic [X_WIDTH-1:0] X_ONE = 1;
   localparam logic [Y_WIDTH-1:0] Y_ONE = 1;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t                  state_q, state_nxt;
   logic [X_WIDTH-1:0]      lat_x_q, lat_x_nxt, lat_w_q, lat_w_nxt, col_q, col_nxt;
   logic [Y_WIDTH-1:0]      lat_y_q, lat_y_nxt, lat_h_q, lat_h_nxt, row_q, row_nxt;
   logic [COLOUR_WIDTH-1:0] colour_q, colour_nxt;
   logic [X_WIDTH-1:0]      x_q, x_nxt, base_x;
   logic [Y_WIDTH-1:0]      y_q, y_nxt, base_y;
   logic                    busy_q, busy_nxt, done_q, done_nxt, plot_q, plot_nxt;
   logic                    emit;
   logic [SUM_XW-1:0]       sum_x;
   logic [SUM_YW-1:0]       sum_y;

   // Outputs for a pixel are registered on the same edge that selects it, so the
   // accepting edge already emits pixel (0,0) from the live command inputs.
   always_comb begin
      state_nxt  = state_q;
      lat_x_nxt  = lat_x_q;
      lat_y_nxt  = lat_y_q;
      lat_w_nxt  = lat_w_q;
      lat_h_nxt  = lat_h_q;
      col_nxt    = col_q;
      row_nxt    = row_q;
      colour_nxt = colour_q;
      base_x     = lat_x_q;
      base_y     = lat_y_q;
      emit       = 1'b0;
      done_nxt   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (bus.start) begin
               lat_x_nxt  = bus.rect_x;
               lat_y_nxt  = bus.rect_y;
               lat_w_nxt  = bus.rect_w;
               lat_h_nxt  = bus.rect_h;
               colour_nxt = bus.rect_colour;
               col_nxt    = '0;
               row_nxt    = '0;
               if (bus.rect_w != '0 && bus.rect_h != '0) begin
                  state_nxt = DRAW;
                  emit      = 1'b1;
                  base_x    = bus.rect_x;
                  base_y    = bus.rect_y;
               end else begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end
            end
         end
         DRAW: begin
            if (col_q == lat_w_q - X_ONE) begin
               col_nxt = '0;
               if (row_q == lat_h_q - Y_ONE) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else begin
                  row_nxt = row_q + Y_ONE;
                  emit    = 1'b1;
               end
            end else begin
               col_nxt = col_q + X_ONE;
               emit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = emit;
      sum_x    = SUM_XW'(base_x) + SUM_XW'(col_nxt);
      sum_y    = SUM_YW'(base_y) + SUM_YW'(row_nxt);
      x_nxt    = emit ? sum_x[X_WIDTH-1:0] : x_q;
      y_nxt    = emit ? sum_y[Y_WIDTH-1:0] : y_q;
`ifdef VGA_RECT_CLIP_EN
      plot_nxt = emit && (sum_x < SUM_XW'(SCREEN_W)) && (sum_y < SUM_YW'(SCREEN_H));
`else
      plot_nxt = emit;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         lat_x_q  <= '0;
         lat_y_q  <= '0;
         lat_w_q  <= '0;
         lat_h_q  <= '0;
         col_q    <= '0;
         row_q    <= '0;
         colour_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         lat_x_q  <= lat_x_nxt;
         lat_y_q  <= lat_y_nxt;
         lat_w_q  <= lat_w_nxt;
         lat_h_q  <= lat_h_nxt;
         col_q    <= col_nxt;
         row_q    <= row_nxt;
         colour_q <= colour_nxt;
         x_q      <= x_nxt;
         y_q      <= y_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         plot_q   <= plot_nxt;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.plot   = plot_q;
   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
endmodule

// File: tb/tb_vga_rect_filler.sv
// Bench for vga_rect_filler: directed scenarios plus random commands against a raster-order model.
// Build with or without VGA_RECT_CLIP_EN to match the RTL configuration.
module tb_vga_rect_filler;
   localparam int XW = 9;
   localparam int YW = 8;
   localparam int CW = 3;
`ifdef VGA_RECT_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   typedef logic [3+XW+YW+CW-1:0] vec_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   vga_rect_filler_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) vif ();

   vga_rect_filler dut (
      .clock (clock),
      .reset (reset),
      .bus   (vif)
   );

   // {busy, done, plot, x, y, colour}
   function automatic vec_t observed();
      return {vif.busy, vif.done, vif.plot, vif.x, vif.y, vif.colour};
   endfunction

   function automatic logic [2:0] flags();
      return {vif.busy, vif.done, vif.plot};
   endfunction

   // Expected write for the k-th pixel of a rectangle in raster order.
   function automatic vec_t model_pix(int rx, int ry, int w, int c, int k);
      int sx, sy;
      bit p;
      sx = rx + (k % w);
      sy = ry + (k / w);
      p  = CLIP ? (sx < 320 && sy < 240) : 1'b1;
      return {1'b1, 1'b0, p, XW'(sx % (1 << XW)), YW'(sy % (1 << YW)), CW'(c)};
   endfunction

   task automatic drive_cmd(input int rx, input int ry, input int w, input int h, input int c);
      vif.start       = 1'b1;
      vif.rect_x      = XW'(rx);
      vif.rect_y      = YW'(ry);
      vif.rect_w      = XW'(w);
      vif.rect_h      = YW'(h);
      vif.rect_colour = CW'(c);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vif.start = 1'b0;
      drive_cmd(0, 0, 0, 0, 0);
      vif.start = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (observed() !== '0) begin
         errors++;
         $display("FAIL reset_state got %h expected %h", observed(), vec_t'(0));
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (observed() !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got %h expected %h", observed(), vec_t'(0));
      end
   endtask

   task automatic test_basic_and_back_to_back();
      vec_t e;
      drive_cmd(10, 20, 3, 2, 6);
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (k == 0) vif.start = 1'b0;
         e = model_pix(10, 20, 3, 6, k);
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL basic_pix%0d got %h expected %h", k, observed(), e);
         end
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b010) begin
         errors++;
         $display("FAIL basic_done got %b expected 010", flags());
      end
      drive_cmd(0, 0, 1, 1, 1);
      @(negedge clock);
      vif.start = 1'b0;
      e = {3'b101, XW'(0), YW'(0), CW'(1)};
      checks++;
      if (observed() !== e) begin
         errors++;
         $display("FAIL b2b_pix got %h expected %h", observed(), e);
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b010) begin
         errors++;
         $display("FAIL b2b_done got %b expected 010", flags());
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b000) begin
         errors++;
         $display("FAIL b2b_idle got %b expected 000", flags());
      end
   endtask

   task automatic test_empty();
      for (int t = 0; t < 2; t++) begin
         @(negedge clock);
         if (t == 0) drive_cmd(4, 4, 0, 5, 2);
         else        drive_cmd(4, 4, 7, 0, 2);
         @(negedge clock);
         vif.start = 1'b0;
         checks++;
         if (flags() !== 3'b010) begin
            errors++;
            $display("FAIL empty%0d_done got %b expected 010", t, flags());
         end
         @(negedge clock);
         checks++;
         if (flags() !== 3'b000) begin
            errors++;
            $display("FAIL empty%0d_idle got %b expected 000", t, flags());
         end
      end
   endtask

   task automatic test_ignore_while_busy();
      vec_t e;
      @(negedge clock);
      drive_cmd(5, 7, 4, 4, 2);
      for (int k = 0; k < 16; k++) begin
         @(negedge clock);
         e = model_pix(5, 7, 4, 2, k);
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL ignore_pix%0d got %h expected %h", k, observed(), e);
         end
         if (k == 0 || k == 3) vif.start = 1'b0;
         if (k == 2) drive_cmd(0, 0, 1, 1, 5);
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b010) begin
         errors++;
         $display("FAIL ignore_done got %b expected 010", flags());
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b000) begin
         errors++;
         $display("FAIL ignore_no_rerun got %b expected 000", flags());
      end
   endtask

   task automatic test_reset_mid_draw();
      vec_t e;
      int   bad;
      @(negedge clock);
      drive_cmd(30, 40, 8, 8, 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (k == 0) vif.start = 1'b0;
         e = model_pix(30, 40, 8, 3, k);
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL abort_pix%0d got %h expected %h", k, observed(), e);
         end
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (flags() !== 3'b000) begin
         errors++;
         $display("FAIL abort_cut got %b expected 000", flags());
      end
      bad = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clock);
         if (flags() !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_screen_edge();
      vec_t e;
      @(negedge clock);
      drive_cmd(318, 239, 4, 2, 4);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (k == 0) vif.start = 1'b0;
         e = model_pix(318, 239, 4, 4, k);
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL edge_pix%0d got %h expected %h", k, observed(), e);
         end
      end
      @(negedge clock);
      checks++;
      if (flags() !== 3'b010) begin
         errors++;
         $display("FAIL edge_done got %b expected 010", flags());
      end
   endtask

   task automatic test_random();
      vec_t e;
      int   rx, ry, w, h, c;
      bit   chained;
      chained = 1'b0;
      rx = $urandom_range(0, 511); ry = $urandom_range(0, 255);
      w  = $urandom_range(1, 10);  h  = $urandom_range(1, 5);  c = $urandom_range(0, 7);
      for (int i = 0; i < 25; i++) begin
         if (!chained) begin
            @(negedge clock);
            drive_cmd(rx, ry, w, h, c);
         end
         for (int k = 0; k < w * h; k++) begin
            @(negedge clock);
            if (k == 0) vif.start = 1'b0;
            e = model_pix(rx, ry, w, c, k);
            checks++;
            if (observed() !== e) begin
               errors++;
               $display("FAIL rand%0d_pix%0d got %h expected %h", i, k, observed(), e);
            end
         end
         @(negedge clock);
         checks++;
         if (flags() !== 3'b010) begin
            errors++;
            $display("FAIL rand%0d_done got %b expected 010", i, flags());
         end
         rx = $urandom_range(0, 511); ry = $urandom_range(0, 255);
         c  = $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) begin
            w = $urandom_range(200, 511); h = 1;
         end else begin
            w = $urandom_range(1, 10); h = $urandom_range(1, 5);
         end
         chained = (i < 24) && ($urandom_range(0, 1) == 1);
         if (chained) drive_cmd(rx, ry, w, h, c);
      end
   endtask

   initial begin
      test_reset();
      test_basic_and_back_to_back();
      test_empty();
      test_ignore_while_busy();
      test_reset_mid_draw();
      test_screen_edge();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
